lcd_rx_capture: RTL

Receiver for the 8-bit serial-RGB LCD stream that the video block drives (lcd_dat, lcd_hsync, lcd_vsync, lcd_den). It reassembles R/G/B byte triplets into 24-bit pixels tagged with x/y coordinates and flags framing errors. It is used as an on-chip loopback checker behind the LCD pins and as the bench-side monitor for the video and scrolling frame-buffer path.

---
 rtl/lcd_rx_capture.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/lcd_rx_capture.sv
// Serial-RGB LCD receiver: rebuilds {R,G,B} pixels with x/y tags and flags framing errors.
// Latency 2 clk pin-to-strobe; no backpressure, the consumer must take every strobe.
module lcd_rx_capture #(
   parameter int H_VISIBLE = 320,
   parameter int V_VISIBLE = 240
) (
   input  logic        clk_i,
   input  logic        resetn_i,
   input  logic [7:0]  lcd_dat_i,
   input  logic        lcd_hsync_i,
   input  logic        lcd_vsync_i,
   input  logic        lcd_den_i,
   input  logic        err_clr_i,
   output logic        pix_valid_o,
   output logic [23:0] pix_rgb_o,
   output logic [8:0]  pix_x_o,
   output logic [7:0]  pix_y_o,
   output logic        line_end_o,
   output logic        frame_start_o,
   output logic [15:0] frame_count_o,
   output logic        in_frame_o,
   output logic [3:0]  err_o
);

   typedef enum logic {SYNC_WAIT, CAPTURE} state_e;

   localparam logic [9:0] H_LEN = 10'(H_VISIBLE);
   localparam logic [8:0] V_LEN = 9'(V_VISIBLE);

   state_e      state_q, state_d;
   logic [7:0]  dat_q;
   logic        hs_q, vs_q, den_q, clr_q;
   logic        vs_p_q, den_p_q;
   logic [1:0]  phase_q, phase_d;
   logic [7:0]  r_q, r_d, g_q, g_d;
   logic [9:0]  col_q, col_d;
   logic [8:0]  line_q, line_d;
   logic        discard_q, discard_d;
   logic        pix_valid_q, pix_valid_d;
   logic [23:0] pix_rgb_q, pix_rgb_d;
   logic [8:0]  pix_x_q, pix_x_d;
   logic [7:0]  pix_y_q, pix_y_d;
   logic        line_end_q, line_end_d;
   logic        frame_start_q, frame_start_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [3:0]  err_q, err_d, err_set;
   logic        capture, vs_fall, den_fall, drop;

   always_comb begin
      state_d       = state_q;
      phase_d       = 2'd0;
      r_d           = r_q;
      g_d           = g_q;
      col_d         = col_q;
      line_d        = line_q;
      pix_valid_d   = 1'b0;
      pix_rgb_d     = pix_rgb_q;
      pix_x_d       = pix_x_q;
      pix_y_d       = pix_y_q;
      line_end_d    = 1'b0;
      frame_start_d = 1'b0;
      frame_cnt_d   = frame_cnt_q;
      err_set       = 4'b0000;

      capture  = (state_q == CAPTURE);
      vs_fall  = vs_p_q & ~vs_q;
      den_fall = den_p_q & ~den_q;
      // a vsync landing inside an active line kills the rest of that line
      drop      = discard_q | (vs_fall & den_q);
      discard_d = drop & den_q;

      if (capture && den_q && !drop) begin
         phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
         case (phase_q)
            2'd0: r_d = dat_q;
            2'd1: g_d = dat_q;
            default: begin
               if ((col_q < H_LEN) && (line_q < V_LEN)) begin
                  pix_valid_d = 1'b1;
                  pix_rgb_d   = {r_q, g_q, dat_q};
                  pix_x_d     = col_q[8:0];
                  pix_y_d     = line_q[7:0];
               end
               if (col_q != 10'h3FF) col_d = col_q + 10'd1;
            end
         endcase
      end

      if (capture && den_q && (!hs_q || !vs_q)) err_set[3] = 1'b1;

      if (capture && den_fall && !discard_q) begin
         line_end_d = 1'b1;
         if (phase_q != 2'd0) err_set[1] = 1'b1;
         if (col_q != H_LEN)  err_set[0] = 1'b1;
         col_d = 10'd0;
         if (line_q != 9'h1FF) line_d = line_q + 9'd1;
      end

      if (vs_fall) begin
         frame_start_d = 1'b1;
         if (capture) begin
            if (line_d != V_LEN) err_set[2] = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
         end else begin
            state_d = CAPTURE;
         end
         col_d  = 10'd0;
         line_d = 9'd0;
      end

      err_d = (clr_q ? 4'b0000 : err_q) | err_set;
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q       <= SYNC_WAIT;
         dat_q         <= 8'd0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         den_q         <= 1'b0;
         clr_q         <= 1'b0;
         vs_p_q        <= 1'b1;
         den_p_q       <= 1'b0;
         phase_q       <= 2'd0;
         r_q           <= 8'd0;
         g_q           <= 8'd0;
         col_q         <= 10'd0;
         line_q        <= 9'd0;
         discard_q     <= 1'b0;
         pix_valid_q   <= 1'b0;
         pix_rgb_q     <= 24'd0;
         pix_x_q       <= 9'd0;
         pix_y_q       <= 8'd0;
         line_end_q    <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= 16'd0;
         err_q         <= 4'd0;
      end else begin
         state_q       <= state_d;
         dat_q         <= lcd_dat_i;
         hs_q          <= lcd_hsync_i;
         vs_q          <= lcd_vsync_i;
         den_q         <= lcd_den_i;
         clr_q         <= err_clr_i;
         vs_p_q        <= vs_q;
         den_p_q       <= den_q;
         phase_q       <= phase_d;
         r_q           <= r_d;
         g_q           <= g_d;
         col_q         <= col_d;
         line_q        <= line_d;
         discard_q     <= discard_d;
         pix_valid_q   <= pix_valid_d;
         pix_rgb_q     <= pix_rgb_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         line_end_q    <= line_end_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
         err_q         <= err_d;
      end
   end

   assign pix_valid_o   = pix_valid_q;
   assign pix_rgb_o     = pix_rgb_q;
   assign pix_x_o       = pix_x_q;
   assign pix_y_o       = pix_y_q;
   assign line_end_o    = line_end_q;
   assign frame_start_o = frame_start_q;
   assign frame_count_o = frame_cnt_q;
   assign in_frame_o    = (state_q == CAPTURE);
   assign err_o         = err_q;

endmodule
